// File: rtl/mc_defs_pkg.sv
// -----------------------------------------------------------------------------
// mc_defs_pkg
// Shared definitions for the multi-cycle controller: state encodings, the
// opcode constants recognised in DECODE, and the select encodings driven onto
// the datapath muxes (alu_src_b, alu_op, pc_source).
// -----------------------------------------------------------------------------
package mc_defs_pkg;

  localparam int unsigned WAIT_CNT_W = 8;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that sit on the shared memory port waiting for mem_ready.
  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
  endfunction

  function automatic logic opcode_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// -----------------------------------------------------------------------------
// mc_wait_timer
// Counts consecutive cycles a memory wait state sees mem_ready=0 and flags the
// cycle in which the tolerance is used up.
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   clear       zero the count (state change or abort); wins over enable
//   enable      a wait state saw mem_ready=0 this cycle
//   timeout     enable is high and the count already sits at MEM_WAIT_MAX-1
// -----------------------------------------------------------------------------
module mc_wait_timer
  import mc_defs_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam logic [WAIT_CNT_W-1:0] CNT_LAST = WAIT_CNT_W'(MEM_WAIT_MAX - 1);

  logic [WAIT_CNT_W-1:0] wait_cnt;

  assign timeout = enable && (wait_cnt == CNT_LAST);

  // A timeout always arrives with clear, so the count never passes CNT_LAST.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (clear) begin
      wait_cnt <= '0;
    end else if (enable) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mc_control_fsm.sv
// -----------------------------------------------------------------------------
// mc_control_fsm
// Main controller of the multi-cycle datapath. Sequences fetch, decode,
// execute, memory and writeback and drives every datapath select/strobe.
// Memory accesses wait on mem_ready with a bounded timeout (MEM_WAIT_MAX).
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   opcode              IR[31:26], looked at only in DECODE
//   mem_ready           memory completes the current access this cycle
//   pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
//   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source
//                       datapath selects and strobes
//   instr_done          pulse in the final cycle of a retired instruction
//   illegal_op          pulse: unknown opcode in DECODE
//   mem_error           pulse: memory wait timed out, instruction aborted
//   state_dbg           current state encoding
// -----------------------------------------------------------------------------
module mc_control_fsm
  import mc_defs_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_error,
  output logic [3:0] state_dbg
);

  state_t state;
  state_t state_nxt;
  logic   store_op;   // lw/sw choice remembered from DECODE
  logic   wait_en;
  logic   timeout;
  logic   cnt_clear;

  assign wait_en   = is_wait_state(state) && !mem_ready;
  assign cnt_clear = (state_nxt != state) || timeout;
  assign state_dbg = state;

  mc_wait_timer #(
    .MEM_WAIT_MAX (MEM_WAIT_MAX)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (cnt_clear),
    .enable  (wait_en),
    .timeout (timeout)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:     if (mem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_nxt = S_EXECUTE;
          OP_LW, OP_SW: state_nxt = S_MEM_ADDR;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_ADDI:      state_nxt = S_ADDI_EXEC;
          OP_J:         state_nxt = S_JUMP;
          default:      state_nxt = S_FETCH;
        endcase
      end
      S_MEM_ADDR:  state_nxt = store_op ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (mem_ready) state_nxt = S_MEM_WB;
      S_MEM_WRITE: if (mem_ready) state_nxt = S_FETCH;
      S_EXECUTE:   state_nxt = S_ALU_WB;
      S_ADDI_EXEC: state_nxt = S_ADDI_WB;
      S_MEM_WB, S_ALU_WB, S_BRANCH, S_JUMP, S_ADDI_WB:
                   state_nxt = S_FETCH;
      default:     state_nxt = S_FETCH;
    endcase
    // Timeout aborts; in FETCH this is a refetch that keeps the state.
    if (timeout) state_nxt = S_FETCH;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_FETCH;
      store_op <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE) store_op <= (opcode == OP_SW);
    end
  end

  // Moore decode; only FETCH and MEM_WRITE strobes look at mem_ready.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_RT;
    alu_op        = ALUOP_ADD;
    pc_source     = PCSRC_ALU;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b  = SRCB_IMM_SH2;
        illegal_op = !opcode_legal(opcode);
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALU_WB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        instr_done    = 1'b1;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = PCSRC_JUMP;
        instr_done = 1'b1;
      end
      S_ADDI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
    mem_error = timeout;
    // Reset suppresses every strobe at once, so nothing half-completes.
    if (reset) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      instr_done    = 1'b0;
      illegal_op    = 1'b0;
      mem_error     = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
module tb_mc_control_fsm;

  localparam int MAXW = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic       instr_done, illegal_op, mem_error;
  logic [3:0] state_dbg;

  typedef struct packed {
    logic pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic instr_done, illegal_op, mem_error;
    logic [3:0] state;
  } outs_t;

  typedef struct {
    logic [5:0] op;
    logic       rdy;
    logic [3:0] st;
    logic       rw, done, m2r, dst;
    logic [1:0] aop;
  } vec_t;

  outs_t act, smp;
  int    n_cmp = 0;
  int    n_bad = 0;

  // Reference model: an instruction is a recipe of steps chosen at decode.
  int m_step;
  int m_wc;
  int m_plan[$];

  always #5 clk = ~clk;

  assign act = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                pc_source, instr_done, illegal_op, mem_error, state_dbg};

  mc_control_fsm #(.MEM_WAIT_MAX(MAXW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .instr_done(instr_done), .illegal_op(illegal_op),
    .mem_error(mem_error), .state_dbg(state_dbg)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic waiting_step(input int s);
    return (s == 0) || (s == 3) || (s == 5);
  endfunction

  function automatic logic known_op(input logic [5:0] op);
    return (op == 6'h00) || (op == 6'h23) || (op == 6'h2B) ||
           (op == 6'h04) || (op == 6'h08) || (op == 6'h02);
  endfunction

  function automatic outs_t model_out(input logic [5:0] op, input logic rdy);
    outs_t e;
    e = '0;
    e.state = 4'(m_step);
    e.mem_error = waiting_step(m_step) && !rdy && (m_wc == MAXW - 1);
    case (m_step)
      0:  begin e.mem_read = 1; e.alu_src_b = 2'b01; e.ir_write = rdy; e.pc_write = rdy; end
      1:  begin e.alu_src_b = 2'b11; e.illegal_op = !known_op(op); end
      2:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      3:  begin e.mem_read = 1; e.i_or_d = 1; end
      4:  begin e.mem_to_reg = 1; e.reg_write = 1; e.instr_done = 1; end
      5:  begin e.mem_write = 1; e.i_or_d = 1; e.instr_done = rdy; end
      6:  begin e.alu_src_a = 1; e.alu_op = 2'b10; end
      7:  begin e.reg_dst = 1; e.reg_write = 1; e.instr_done = 1; end
      8:  begin e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_write_cond = 1;
                e.pc_source = 2'b01; e.instr_done = 1; end
      9:  begin e.pc_write = 1; e.pc_source = 2'b10; e.instr_done = 1; end
      10: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      11: begin e.reg_write = 1; e.instr_done = 1; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic model_adv(input logic [5:0] op, input logic rdy);
    logic stalled;
    stalled = waiting_step(m_step) && !rdy;
    if (stalled && m_wc == MAXW - 1) begin
      m_plan.delete();
      m_step = 0;
      m_wc = 0;
    end else if (stalled) begin
      m_wc++;
    end else begin
      m_wc = 0;
      if (m_step == 0) m_plan.push_back(1);
      else if (m_step == 1) begin
        case (op)
          6'h00: begin m_plan.push_back(6); m_plan.push_back(7); end
          6'h23: begin m_plan.push_back(2); m_plan.push_back(3); m_plan.push_back(4); end
          6'h2B: begin m_plan.push_back(2); m_plan.push_back(5); end
          6'h04: m_plan.push_back(8);
          6'h08: begin m_plan.push_back(10); m_plan.push_back(11); end
          6'h02: m_plan.push_back(9);
          default: ;
        endcase
      end
      m_step = (m_plan.size() > 0) ? m_plan.pop_front() : 0;
    end
  endtask

  task automatic model_reset();
    m_plan.delete();
    m_step = 0;
    m_wc = 0;
  endtask

  // One clock: drive at posedge+1, check at negedge, advance model.
  task automatic cycle(input logic [5:0] op, input logic rdy);
    outs_t e;
    opcode = op;
    mem_ready = rdy;
    @(negedge clk);
    e = model_out(op, rdy);
    chk($sformatf("model_step%0d", m_step), 32'(act), 32'(e));
    smp = act;
    model_adv(op, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic to_fetch();
    for (int i = 0; i < 8 && m_step != 0; i++) cycle(6'h00, 1'b1);
  endtask

  initial begin
    vec_t tbl[16];
    int   stall;
    logic [5:0] picks[8];
    tbl = '{
      '{6'h23, 1, 4'd0,  0, 0, 0, 0, 2'd0},
      '{6'h23, 1, 4'd1,  0, 0, 0, 0, 2'd0},
      '{6'h23, 1, 4'd2,  0, 0, 0, 0, 2'd0},
      '{6'h23, 1, 4'd3,  0, 0, 0, 0, 2'd0},
      '{6'h23, 1, 4'd4,  1, 1, 1, 0, 2'd0},
      '{6'h00, 1, 4'd0,  0, 0, 0, 0, 2'd0},
      '{6'h00, 1, 4'd1,  0, 0, 0, 0, 2'd0},
      '{6'h00, 1, 4'd6,  0, 0, 0, 0, 2'd2},
      '{6'h00, 1, 4'd7,  1, 1, 0, 1, 2'd0},
      '{6'h08, 1, 4'd0,  0, 0, 0, 0, 2'd0},
      '{6'h08, 1, 4'd1,  0, 0, 0, 0, 2'd0},
      '{6'h08, 1, 4'd10, 0, 0, 0, 0, 2'd0},
      '{6'h08, 1, 4'd11, 1, 1, 0, 0, 2'd0},
      '{6'h04, 1, 4'd0,  0, 0, 0, 0, 2'd0},
      '{6'h04, 1, 4'd1,  0, 0, 0, 0, 2'd0},
      '{6'h04, 1, 4'd8,  0, 1, 0, 0, 2'd1}
    };

    reset = 1'b1;
    opcode = 6'h00;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state_strobes",
        {state_dbg, pc_write, pc_write_cond, ir_write, reg_write, mem_read,
         mem_write, instr_done, illegal_op, mem_error}, 32'h0);
    reset = 1'b0;
    model_reset();

    // Table: lw (5 cycles), R-type (4), addi (4), beq (3).
    for (int i = 0; i < 16; i++) begin
      cycle(tbl[i].op, tbl[i].rdy);
      chk($sformatf("tbl_row%0d", i),
          {smp.state, smp.reg_write, smp.instr_done, smp.mem_to_reg, smp.reg_dst, smp.alu_op},
          {tbl[i].st, tbl[i].rw, tbl[i].done, tbl[i].m2r, tbl[i].dst, tbl[i].aop});
    end

    // sw held three cycles by mem_ready=0.
    to_fetch();
    repeat (3) cycle(6'h2B, 1'b1);
    for (int k = 0; k < 4; k++) begin
      cycle(6'h2B, k == 3);
      chk($sformatf("sw_wait%0d", k), {smp.state, smp.mem_write, smp.instr_done},
          {4'd5, 1'b1, 1'(k == 3)});
    end
    cycle(6'h00, 1'b1);
    chk("sw_back_to_fetch", smp.state, 4'd0);

    // lw with memory stuck: abort on the 4th wait cycle.
    to_fetch();
    repeat (3) cycle(6'h23, 1'b1);
    for (int k = 0; k < 4; k++) begin
      cycle(6'h23, 1'b0);
      chk($sformatf("lw_timeout%0d", k), {smp.state, smp.mem_error, smp.reg_write},
          {4'd3, 1'(k == 3), 1'b0});
    end
    cycle(6'h3F, 1'b1);
    chk("timeout_to_fetch", {smp.state, smp.reg_write}, {4'd0, 1'b0});

    // Illegal opcode, then beq and j.
    to_fetch();
    cycle(6'h3F, 1'b1);
    cycle(6'h3F, 1'b1);
    chk("illegal_decode", {smp.illegal_op, smp.pc_write, smp.pc_write_cond,
        smp.ir_write, smp.reg_write, smp.mem_write}, 6'b100000);
    cycle(6'h04, 1'b1);
    chk("illegal_next_fetch", smp.state, 4'd0);
    cycle(6'h04, 1'b1);
    cycle(6'h04, 1'b1);
    chk("beq_branch", {smp.state, smp.pc_write_cond, smp.pc_source}, {4'd8, 1'b1, 2'b01});
    repeat (2) cycle(6'h02, 1'b1);
    cycle(6'h02, 1'b1);
    chk("j_jump", {smp.state, smp.pc_write, smp.pc_source}, {4'd9, 1'b1, 2'b10});

    // Asynchronous reset in the middle of MEM_WB.
    to_fetch();
    repeat (4) cycle(6'h23, 1'b1);
    opcode = 6'h23;
    mem_ready = 1'b1;
    @(negedge clk);
    chk("mem_wb_before_reset", {state_dbg, reg_write}, {4'd4, 1'b1});
    #1 reset = 1'b1;
    #1;
    chk("async_reset_now", {state_dbg, reg_write, instr_done, mem_read}, 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    chk("reset_held", {state_dbg, reg_write}, 32'h0);
    reset = 1'b0;
    cycle(6'h23, 1'b1);
    cycle(6'h23, 1'b1);
    chk("resume_decode", smp.state, 4'd1);

    // Random traffic against the model.
    picks = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02, 6'h3F, 6'h00};
    stall = 0;
    for (int n = 0; n < 800; n++) begin
      logic [5:0] op;
      op = picks[$urandom_range(0, 7)];
      if ($urandom_range(0, 15) == 0) op = 6'($urandom);
      if (stall == 0 && $urandom_range(0, 7) == 0) stall = $urandom_range(1, 6);
      cycle(op, stall == 0);
      if (stall > 0) stall--;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
